// File: rtl/toggle_sync_pkg.sv
// Shared types and constants for the toggle request/acknowledge receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package toggle_sync_pkg;

    // Receiver control states: power-on alignment, waiting for a toggle, holding an event.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_VALID = 2'd2
    } rx_state_t;

    // Fewer than two flops gives no metastability settling time.
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/toggle_req_ack_rx_bit_sync.sv
// Single-bit flop-chain synchronizer into the i_clk domain.
// Latency: STAGES cycles from i_d sampled to o_q.
// Backpressure: none; free-running shift every cycle.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the chain; synchronous clear to 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_req_ack_rx.sv
// Receive endpoint of a two-phase toggle req/ack link: toggle -> valid/ready event + ack toggle.
// Latency: req toggle to o_valid = SYNC_STAGES+1 edges; acceptance to ack toggle = same edge.
// Backpressure: o_valid holds until i_ready; a source toggle while held is flagged and dropped.
module toggle_req_ack_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_tgl,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_ack_tgl,
    output logic [CNT_W-1:0] o_evt_cnt,
    output logic             o_err
);

    import toggle_sync_pkg::*;

    // INIT lasts SYNC_STAGES+1 cycles so the chain has flushed the source's idle level.
    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("toggle_req_ack_rx: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    logic              w_req_s;
    logic              w_evt;
    logic              r_req_d;
    rx_state_t         r_state;
    logic [INIT_W-1:0] r_init_cnt;
    logic              r_valid;
    logic              r_ack;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_req_tgl),
        .o_q     (w_req_s)
    );

    // A level change on the synchronized request is one event.
    assign w_evt = w_req_s ^ r_req_d;

    // Control FSM with edge detector, ack flop, delivered counter and sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_req_d    <= 1'b0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            // Edge-detect history always tracks, so leaving INIT never sees a stale edge.
            r_req_d <= w_req_s;
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        // Match the source's resting level so no event is implied by it.
                        r_ack   <= w_req_s;
                        r_state <= ST_IDLE;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_evt) begin
                        r_valid <= 1'b1;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // Source toggled again before being acked: flag it, drop that event.
                    if (w_evt) begin
                        r_err <= 1'b1;
                    end
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ack   <= ~r_ack;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign o_valid   = r_valid;
    assign o_ack_tgl = r_ack;
    assign o_evt_cnt = r_cnt;
    assign o_err     = r_err;

endmodule
